deinterleaver: RTL and testbench
================================

# deinterleaver

Receive-side block interleaver inverse for the WiMAX PHY. It sits between the QPSK demapper and the FEC decoder. It accepts one hard bit per cycle in over-the-air order and writes each bit to its original pre-interleave position in a ping-pong buffer. It then streams each completed 192-bit block to the FEC decoder in original order under a valid/ready handshake.

## Interface
- Ncbps, 192: coded bits per block (power-of-two multiples of d not required; Ncbps % d == 0 required).
- Ncpc, 2: coded bits per carrier (2 = QPSK).
- s, Ncpc/2: permutation parameter.
- d, 16: interleaver column count.
- clk  in  1  single clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- valid_demod  in  1  data_in is valid.
- data_in  in  1  received bit, over-the-air order.
- ready_deinterleaver  out  1  block can accept data_in this cycle.
- valid_deinterleaver  out  1  data_out is valid.
- data_out  out  1  deinterleaved bit, original order.
- ready_fec  in  1  FEC decoder accepts data_out.
- data_out_index  out  9  original bit index k of data_out; present only with DEINTERLEAVER_INDEX_EN.

## Operation
- **Storage.** Two banks of Ncbps bits each.
  - One bank is the write bank and the other is the read bank; `wsel` selects which.
  - Storage has no reset.
- **Input transfer.** A bit is accepted when valid_demod && ready_deinterleaver.
  - The write counter j runs 0..Ncbps-1 and wraps to 0 after the last bit of a block.
- **Inverse permutation.** This is the write address, computed combinationally from j:
  - m = s*(j/s) + ((j + (d*j)/Ncbps) % s)
  - k = d*m - (Ncbps-1)*((d*m)/Ncbps)
  - All intermediates are unsigned and 14 bits wide, so there is no overflow at d*Ncbps.
  - With s=1, m = j.
- **Write-side FSM.**
  - FILL: ready_deinterleaver=1.
  - On accepting j=Ncbps-1:
    - If the read side is IDLE, or is draining its last bit in the same cycle, swap banks and stay in FILL.
    - Otherwise go to WAIT.
  - WAIT: ready_deinterleaver=0. When the read side completes its last transfer, swap banks and return to FILL.
- **Read-side FSM.**
  - IDLE: valid_deinterleaver=0.
  - DRAIN: valid_deinterleaver=1, data_out = read_bank[r], where r runs 0..Ncbps-1.
  - Output transfer occurs when valid_deinterleaver && ready_fec; r then increments.
  - On the transfer with r=Ncbps-1: go to DRAIN again if a swap occurs at that edge, otherwise go to IDLE.
- **Swap.** Toggles `wsel`, clears j to 0, clears r to 0, and sets the read side to DRAIN.
- **Output drive.** data_out and valid_deinterleaver are decoded from registers only; there is no combinational path from inputs to outputs.
- **Reset** (asynchronous, at any time, including mid-block):
  - Write side → FILL; read side → IDLE; j=0, r=0, wsel=0.
  - A partially filled block is discarded.

## Timing
- **Output values while resetN is low:** ready_deinterleaver=0, valid_deinterleaver=0, data_out=0, data_out_index=0.
- **After reset release:** ready_deinterleaver=1 from the first cycle.
- **Latency:** the last input bit of a block is accepted at edge T; valid_deinterleaver=1 with k=0 data in cycle T+1.
- **Throughput:** 1 bit/cycle sustained when ready_fec is held high; no bubbles between blocks.
- **Backpressure:**
  - ready_deinterleaver drops in the cycle after a full write bank meets a non-empty read bank.
  - It rises in the cycle after the read bank's last transfer.
- **Output stall:** data_out stays stable while valid_deinterleaver=1 and ready_fec=0.
- **Simultaneous events:**
  - Input j=Ncbps-1 and output r=Ncbps-1 transferring on the same edge cause a swap with valid_deinterleaver continuous and ready_deinterleaver continuous.
  - valid_demod=0 mid-block holds j; the block simply completes later.

## Configuration
- **DEINTERLEAVER_INDEX_EN defined:** the data_out_index port exists and equals r (the original index k) whenever valid_deinterleaver=1; it holds its last value otherwise and is 0 in reset.
- **Not defined:** the port and its register are absent; all other behaviour is identical.

## Structure
- **Shared package `wimax_pkg`:**
  - constants NCBPS=192, D=16, NCPC=2;
  - typedef `bit_idx_t` (logic [8:0]);
  - typedef enum `deint_wr_state_t` {FILL, WAIT};
  - typedef enum `deint_rd_state_t` {IDLE, DRAIN}.
- **Sub-module `deinterleaver_addr`:** purely combinational j→k inverse permutation. It is parameterized like the top level so the bench can check it standalone against the transmit-side interleaver mapping.

## Test plan
- **Mapping check:** feed one block with a single 1 at input position j:
  - j=1 → data_out=1 only at k=16;
  - j=12 → only at k=1;
  - j=191 → only at k=191.
- **Round trip:** transmit-side interleaver output fed into the deinterleaver for 3 random back-to-back blocks with ready_fec=1 → output equals the original input, with 0 bubbles and valid_deinterleaver continuous after the first block.
- **Backpressure:** ready_fec=0 for 400 cycles after the first block while valid_demod=1:
  - ready_deinterleaver drops after the second block fills (192 accepted bits);
  - no data is lost;
  - release of ready_fec restores order.
- **Simultaneous boundary:** align input j=191 and output r=191 on the same edge → swap with no gap in either ready_deinterleaver or valid_deinterleaver.
- **Reset mid-block:** assert resetN=0 after 100 input bits:
  - outputs are 0 immediately;
  - after release, the next full 192 bits form a correct block.
- **Index option:** with DEINTERLEAVER_INDEX_EN, data_out_index sequence is 0..191 per block and holds during a ready_fec stall.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY receive-side types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wimax_pkg;

    localparam int NCBPS = 192;   // coded bits per interleaver block
    localparam int D     = 16;    // interleaver column count
    localparam int NCPC  = 2;     // coded bits per carrier (QPSK)

    typedef logic [8:0] bit_idx_t;

    typedef enum logic {FILL, WAIT}  deint_wr_state_t;
    typedef enum logic {IDLE, DRAIN} deint_rd_state_t;

endpackage

// File: rtl/deinterleaver_if.sv
// Bit-stream bus between demapper, deinterleaver and FEC decoder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input (demod) and output (fec) sides.
// slave  : deinterleaver view (consumes data_in, produces data_out).
// master : environment view (drives data_in and ready_fec).
// data_out_index exists only when DEINTERLEAVER_INDEX_EN is defined.
interface deinterleaver_if;
    import wimax_pkg::*;

    logic     valid_demod;
    logic     data_in;
    logic     ready_deinterleaver;
    logic     valid_deinterleaver;
    logic     data_out;
    logic     ready_fec;
`ifdef DEINTERLEAVER_INDEX_EN
    bit_idx_t data_out_index;

    modport slave (
        input  valid_demod, data_in, ready_fec,
        output ready_deinterleaver, valid_deinterleaver, data_out, data_out_index
    );
    modport master (
        output valid_demod, data_in, ready_fec,
        input  ready_deinterleaver, valid_deinterleaver, data_out, data_out_index
    );
`else
    modport slave (
        input  valid_demod, data_in, ready_fec,
        output ready_deinterleaver, valid_deinterleaver, data_out
    );
    modport master (
        output valid_demod, data_in, ready_fec,
        input  ready_deinterleaver, valid_deinterleaver, data_out
    );
`endif

endinterface

// File: rtl/deinterleaver_addr.sv
// Inverse WiMAX block-interleaver permutation: received position j -> original index k.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: j_i (over-the-air bit position), k_o (original pre-interleave index).
module deinterleaver_addr
    import wimax_pkg::*;
#(
    parameter int P_NCBPS = NCBPS,
    parameter int P_NCPC  = NCPC,
    parameter int P_D     = D
) (
    input  bit_idx_t j_i,
    output bit_idx_t k_o
);

    // s = max(Ncpc/2, 1); QPSK gives s = 1, so the first stage reduces to m = j.
    localparam int          S    = (P_NCPC / 2 > 1) ? (P_NCPC / 2) : 1;
    localparam logic [13:0] S_W  = 14'(S);
    localparam logic [13:0] D_W  = 14'(P_D);
    localparam logic [13:0] N_W  = 14'(P_NCBPS);
    localparam logic [13:0] N1_W = 14'(P_NCBPS - 1);

    // 14-bit intermediates: d*m peaks just under d*Ncbps, which fits without wrap.
    logic [13:0] j_w;
    logic [13:0] m_w;
    logic [13:0] dm_w;
    logic [13:0] k_w;

    always_comb begin
        j_w  = {5'd0, j_i};
        m_w  = S_W * (j_w / S_W) + ((j_w + (D_W * j_w) / N_W) % S_W);
        dm_w = D_W * m_w;
        k_w  = dm_w - N1_W * (dm_w / N_W);
    end

    assign k_o = bit_idx_t'(k_w);

endmodule

// File: rtl/deinterleaver.sv
// WiMAX receive deinterleaver: ping-pong bank written in permuted order, drained in original order.
// Latency: last input bit accepted at edge T -> k=0 bit valid in cycle T+1; 1 bit/cycle sustained.
// Backpressure: ready_deinterleaver drops while a full write bank waits for the read bank to drain.
// Ports: clk, resetN (async active-low), bus (deinterleaver_if.slave).
// Option DEINTERLEAVER_INDEX_EN adds the registered data_out_index output.
module deinterleaver
    import wimax_pkg::*;
#(
    parameter int P_NCBPS = NCBPS,
    parameter int P_NCPC  = NCPC,
    parameter int P_D     = D
) (
    input  logic          clk,
    input  logic          resetN,
    deinterleaver_if.slave bus
);

    localparam int       AW   = $clog2(P_NCBPS);
    localparam bit_idx_t LAST = bit_idx_t'(P_NCBPS - 1);
    localparam bit_idx_t ONE  = bit_idx_t'(1);

    deint_wr_state_t wr_state_q, wr_state_d;
    deint_rd_state_t rd_state_q, rd_state_d;
    bit_idx_t        j_q, j_d;
    bit_idx_t        r_q, r_d;
    logic            wsel_q, wsel_d;
    bit_idx_t        k;

    logic [1:0][P_NCBPS-1:0] bank_q, bank_d;

    logic rdy;
    logic acc;
    logic out_xfer;
    logic wr_last;
    logic rd_last;
    logic swap;

    deinterleaver_addr #(
        .P_NCBPS (P_NCBPS),
        .P_NCPC  (P_NCPC),
        .P_D     (P_D)
    ) u_addr (
        .j_i (j_q),
        .k_o (k)
    );

    always_comb begin
        // Qualify with resetN so ready reads 0 while reset is held.
        rdy      = (wr_state_q == FILL) && resetN;
        acc      = rdy && bus.valid_demod;
        out_xfer = (rd_state_q == DRAIN) && bus.ready_fec;
        wr_last  = acc && (j_q == LAST);
        rd_last  = out_xfer && (r_q == LAST);
        // Swap when a full write bank meets an empty (or just-emptied) read bank.
        swap     = ((wr_state_q == FILL) && wr_last && ((rd_state_q == IDLE) || rd_last)) ||
                   ((wr_state_q == WAIT) && rd_last);

        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        wsel_d     = wsel_q;
        j_d        = j_q;
        r_d        = r_q;

        if (acc) begin
            j_d = wr_last ? '0 : j_q + ONE;
        end
        if (out_xfer) begin
            r_d = rd_last ? '0 : r_q + ONE;
        end

        if (wr_last && !swap) begin
            wr_state_d = WAIT;
        end

        if (swap) begin
            wr_state_d = FILL;
            rd_state_d = DRAIN;
            wsel_d     = ~wsel_q;
            j_d        = '0;
            r_d        = '0;
        end else if (rd_last) begin
            rd_state_d = IDLE;
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (acc) begin
            bank_d[wsel_q][AW'(k)] = bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_state_q <= FILL;
            rd_state_q <= IDLE;
            wsel_q     <= 1'b0;
            j_q        <= '0;
            r_q        <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wsel_q     <= wsel_d;
            j_q        <= j_d;
            r_q        <= r_d;
        end
    end

    // Storage carries no reset; a reset simply abandons whatever the banks hold.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign bus.ready_deinterleaver = rdy;
    assign bus.valid_deinterleaver = (rd_state_q == DRAIN);
    assign bus.data_out            = (rd_state_q == DRAIN) ? bank_q[~wsel_q][AW'(r_q)] : 1'b0;

`ifdef DEINTERLEAVER_INDEX_EN
    bit_idx_t idx_q, idx_d;

    // Tracks r while draining and holds the last index once the read side goes idle.
    always_comb begin
        idx_d = idx_q;
        if (rd_state_d == DRAIN) begin
            idx_d = r_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign bus.data_out_index = idx_q;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
module tb_deinterleaver;
    import wimax_pkg::*;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    deinterleaver_if bus();

    deinterleaver #(
        .P_NCBPS (NCBPS),
        .P_NCPC  (NCPC),
        .P_D     (D)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    bit_idx_t addr_j;
    bit_idx_t addr_k;

    deinterleaver_addr #(
        .P_NCBPS (NCBPS),
        .P_NCPC  (NCPC),
        .P_D     (D)
    ) u_addr (
        .j_i (addr_j),
        .k_o (addr_k)
    );

    int n_assert = 0;
    int n_fail   = 0;

    bit in_q[$];
    bit exp_q[$];
    bit fec_rdy = 1'b0;
    bit in_en   = 1'b0;

    int n_acc      = 0;
    int n_bubble   = 0;
    int n_rdy_low  = 0;
    int out_k      = 0;
    int one_k      = -1;
    bit seen_valid = 1'b0;
    bit last_valid = 1'b0;
    bit last_rdy   = 1'b0;
    bit stall_prev = 1'b0;
    bit stall_dat  = 1'b0;
    int stall_idx  = 0;

    int map_j[3] = '{1, 12, 191};
    int map_k[3] = '{16, 1, 191};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Transmit-side interleaver: original index k -> over-the-air position j.
    function automatic int tx_perm(input int k);
        int s;
        int m;
        s = (NCPC / 2 > 1) ? (NCPC / 2) : 1;
        m = (NCBPS / D) * (k % D) + k / D;
        return s * (m / s) + ((m + NCBPS - (D * m) / NCBPS) % s);
    endfunction

    task automatic push_orig(input logic [NCBPS-1:0] orig);
        logic [NCBPS-1:0] tx;
        tx = '0;
        for (int k = 0; k < NCBPS; k++) tx[tx_perm(k)] = orig[k];
        for (int j = 0; j < NCBPS; j++) in_q.push_back(tx[j]);
        for (int k = 0; k < NCBPS; k++) exp_q.push_back(orig[k]);
    endtask

    function automatic logic [NCBPS-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: drive inputs after negedge, sample outputs, account for the coming edge.
    task automatic tick();
        @(negedge clk);
        bus.valid_demod = in_en && (in_q.size() > 0);
        bus.data_in     = (in_q.size() > 0) ? in_q[0] : 1'b0;
        bus.ready_fec   = fec_rdy;
        #1;
        last_valid = bus.valid_deinterleaver;
        last_rdy   = bus.ready_deinterleaver;
        if (stall_prev) begin
            chk("stall_valid", bus.valid_deinterleaver, 1);
            chk("stall_data", bus.data_out, stall_dat);
`ifdef DEINTERLEAVER_INDEX_EN
            chk("stall_index", bus.data_out_index, stall_idx);
`endif
        end
        if (bus.valid_deinterleaver) begin
            seen_valid = 1'b1;
            if (fec_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("data", bus.data_out, exp_q.pop_front());
                end
`ifdef DEINTERLEAVER_INDEX_EN
                chk("index", bus.data_out_index, out_k);
`endif
                if (bus.data_out) one_k = out_k;
                out_k = (out_k + 1) % NCBPS;
            end
        end else if (seen_valid && exp_q.size() > 0) begin
            n_bubble++;
        end
        stall_prev = bus.valid_deinterleaver && !fec_rdy;
        stall_dat  = bus.data_out;
`ifdef DEINTERLEAVER_INDEX_EN
        stall_idx  = bus.data_out_index;
`endif
        if (!bus.ready_deinterleaver) n_rdy_low++;
        if (bus.ready_deinterleaver && bus.valid_demod) begin
            void'(in_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", in_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.ready_deinterleaver, 0);
        chk({tag, "_valid"}, bus.valid_deinterleaver, 0);
        chk({tag, "_data"}, bus.data_out, 0);
`ifdef DEINTERLEAVER_INDEX_EN
        chk({tag, "_index"}, bus.data_out_index, 0);
`endif
    endtask

    initial begin
        bus.valid_demod = 1'b0;
        bus.data_in     = 1'b0;
        bus.ready_fec   = 1'b0;
        addr_j          = '0;

        // Reset state and first-cycle ready.
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("ready_after_release", bus.ready_deinterleaver, 1);

        // Standalone address map against the transmit permutation.
        for (int k = 0; k < NCBPS; k++) begin
            addr_j = bit_idx_t'(tx_perm(k));
            #1;
            chk("addr_map", addr_k, k);
        end

        // Single-one mapping blocks, plus first-bit latency.
        in_en   = 1'b1;
        fec_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            logic [NCBPS-1:0] orig;
            int n;
            for (int k = 0; k < NCBPS; k++) orig[k] = (tx_perm(k) == map_j[t]);
            one_k = -1;
            push_orig(orig);
            n = 0;
            while (in_q.size() > 0 && n < 400) begin
                tick();
                n++;
            end
            tick();
            chk("latency_valid", last_valid, 1);
            run_drain(400);
            chk("map_position", one_k, map_k[t]);
            tick();
        end

        // Three random back-to-back blocks; also aligns j=191 with r=191 at each boundary.
        n_bubble   = 0;
        n_rdy_low  = 0;
        seen_valid = 1'b0;
        for (int b = 0; b < 3; b++) push_orig(rand_block());
        run_drain(1000);
        chk("roundtrip_bubbles", n_bubble, 0);
        chk("roundtrip_ready_low", n_rdy_low, 0);
        tick();

        // Backpressure: FEC stalled for 400 cycles after the first block.
        fec_rdy = 1'b0;
        n_acc   = 0;
        for (int b = 0; b < 3; b++) push_orig(rand_block());
        repeat (192) tick();
        chk("bp_first_block", n_acc, 192);
        repeat (400) tick();
        chk("bp_accepted", n_acc, 384);
        chk("bp_ready_low", last_rdy, 0);
        fec_rdy = 1'b1;
        run_drain(2000);
        tick();

        // Reset in the middle of a block.
        n_acc = 0;
        push_orig(rand_block());
        while (n_acc < 100) tick();
        #3;
        resetN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        in_q.delete();
        exp_q.delete();
        out_k      = 0;
        stall_prev = 1'b0;
        seen_valid = 1'b0;
        bus.valid_demod = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("midreset_ready_release", bus.ready_deinterleaver, 1);
        push_orig(rand_block());
        run_drain(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
